unit_frame_aligner: RTL

- Stage directly downstream of the header seeker. Consumes the seeker's `offset_pos` and `is_synced`, plus the same gearbox buffer stream.
- Extracts aligned 66-bit frames (2-bit header, 64-bit payload) and classifies each one as data or command.
- Monitors header integrity while locked. Drops lock and requests a seeker re-hunt when the header error rate is too high.

---
 rtl/unit_frame_aligner_pkg.sv | 24 ++
 rtl/unit_frame_aligner_hdr_err_monitor.sv | 48 ++++
 rtl/unit_frame_aligner.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/unit_frame_aligner_pkg.sv
// Shared frame definitions for the seeker / aligner pair.
package rd53b_frame_pkg;

  localparam logic [1:0] C_DATA_HEADER = 2'b01;
  localparam logic [1:0] C_CMD_HEADER  = 2'b10;
  localparam int         C_SLICE_W     = 67;
  localparam int         C_FRAME_W     = 66;

  typedef struct packed {
    logic [1:0]  hdr;
    logic [63:0] data;
  } frame_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } align_state_e;

  // Only 01 (data) and 10 (command) are legal sync headers.
  function automatic logic hdr_is_bad(input logic [1:0] hdr);
    return (hdr != C_DATA_HEADER) && (hdr != C_CMD_HEADER);
  endfunction

endpackage

// File: rtl/unit_frame_aligner_hdr_err_monitor.sv
// Windowed bad-header counter. Windows are aligned to the lock point:
// frames 0..WINDOW-1 after lock form the first window, and so on. A frame
// arriving with the window counter at zero starts a fresh window, so its own
// error (if any) is the first one counted in that window.
module unit_hdr_err_monitor
  import rd53b_frame_pkg::*;
#(
  parameter int BAD_HDR_MAX = 8,
  parameter int WINDOW      = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic frame_stb,
  input  logic hdr_err,
  input  logic clear,
  output logic thresh
);

  localparam int WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int BAD_W  = $clog2(WINDOW + 1);

  logic [WCNT_W-1:0] wcnt_p0;
  logic [BAD_W-1:0]  bad_p0;
  logic [BAD_W-1:0]  bad_base;
  logic [BAD_W-1:0]  bad_next;

  // Bad count including the current frame, compared after the increment.
  always_comb begin
    bad_base = (wcnt_p0 == '0) ? '0 : bad_p0;
    bad_next = bad_base + BAD_W'(hdr_err);
    thresh   = frame_stb && (bad_next >= BAD_W'(BAD_HDR_MAX));
  end

  // Window position and running bad count, advanced once per emitted frame.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wcnt_p0 <= '0;
      bad_p0  <= '0;
    end else if (clear) begin
      wcnt_p0 <= '0;
      bad_p0  <= '0;
    end else if (frame_stb) begin
      wcnt_p0 <= (wcnt_p0 == WCNT_W'(WINDOW - 1)) ? '0 : wcnt_p0 + WCNT_W'(1);
      bad_p0  <= bad_next;
    end
  end

endmodule

// File: rtl/unit_frame_aligner.sv
// Frame aligner: cuts 66-bit frames out of the gearbox stream at the offset
// found by the header seeker, classifies them, and supervises lock quality.
module unit_frame_aligner
  import rd53b_frame_pkg::*;
#(
  parameter int BAD_HDR_MAX = 8,
  parameter int WINDOW      = 64,
  parameter int OFFSET_MAX  = 65
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [193:0] gbox_buffer,
  input  logic [5:0]   gbox_cnt,
  input  logic         buffer_dv,
  input  logic         is_synced,
  input  logic [6:0]   offset_pos,
  output logic [1:0]   frame_hdr_o,
  output logic [63:0]  frame_data_o,
  output logic         frame_dv_o,
  output logic         frame_is_cmd_o,
  output logic         hdr_err_o,
  output logic         locked_o,
  output logic         realign_o,
  output logic [7:0]   lock_loss_cnt_o
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  align_state_e           state_p0;
  logic [C_SLICE_W-1:0]   slice_p0;
  logic                   vld_p0;
  logic [6:0]             lock_off;
  logic                   rehunt_wait;

  logic [C_SLICE_W-1:0]   new_slice;
  logic [2*C_SLICE_W-1:0] win;
  logic [7:0]             sel_top;
  logic [7:0]             hdr_top;
  logic [7:0]             data_top;
  frame_t                 cur;
  logic                   cur_bad;
  logic                   qual;
  logic                   lock_ok;
  logic                   stay_ok;
  logic                   do_lock;
  logic                   emit;
  logic                   sync_loss;
  logic                   thresh;
  logic                   bad_drop;

  // Slice selection and frame extraction; frames are only cut at lock_off,
  // which is always a legal offset, so the selects never leave the window.
  always_comb begin
    sel_top   = 8'd193 - {2'b00, gbox_cnt};
    new_slice = gbox_buffer[sel_top -: C_SLICE_W];
    win       = {slice_p0, new_slice};
    hdr_top   = 8'd68 + {1'b0, lock_off};
    data_top  = 8'd66 + {1'b0, lock_off};
    cur.hdr   = win[hdr_top -: 2];
    cur.data  = win[data_top -: (C_FRAME_W - 2)];
    cur_bad   = hdr_is_bad(cur.hdr);
  end

  // Per-buffer_dv decisions; sync loss wins over the header threshold
  // because a sync loss suppresses the frame and the monitor never sees it.
  always_comb begin
    qual      = buffer_dv && vld_p0;
    lock_ok   = is_synced && (offset_pos <= 7'(OFFSET_MAX)) && !rehunt_wait;
    stay_ok   = is_synced && (offset_pos == lock_off);
    do_lock   = qual && (state_p0 == UNLOCKED) && lock_ok;
    emit      = qual && (state_p0 == LOCKED) && stay_ok;
    sync_loss = qual && (state_p0 == LOCKED) && !stay_ok;
  end

  assign bad_drop = emit && thresh;

  unit_hdr_err_monitor #(
    .BAD_HDR_MAX (BAD_HDR_MAX),
    .WINDOW      (WINDOW)
  ) u_mon (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .frame_stb (emit),
    .hdr_err   (cur_bad),
    .clear     (do_lock),
    .thresh    (thresh)
  );

  // Stage p0: previous slice, kept as the upper half of the extraction window.
  always_ff @(posedge clk_i) begin
    if (buffer_dv) slice_p0 <= new_slice;
  end

  // Lock FSM, lock-loss counter and re-hunt request. After a re-hunt the
  // aligner ignores is_synced until the seeker has been seen unsynced.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_p0        <= UNLOCKED;
      locked_o        <= 1'b0;
      lock_off        <= '0;
      vld_p0          <= 1'b0;
      rehunt_wait     <= 1'b0;
      realign_o       <= 1'b0;
      lock_loss_cnt_o <= '0;
    end else begin
      realign_o <= bad_drop;
      if (buffer_dv) vld_p0 <= 1'b1;
      if (bad_drop) rehunt_wait <= 1'b1;
      else if (buffer_dv && !is_synced) rehunt_wait <= 1'b0;
      if (do_lock) begin
        state_p0 <= LOCKED;
        locked_o <= 1'b1;
        lock_off <= offset_pos;
      end else if (sync_loss || bad_drop) begin
        state_p0        <= UNLOCKED;
        locked_o        <= 1'b0;
        lock_loss_cnt_o <= sat_inc8(lock_loss_cnt_o);
      end
    end
  end

  // Stage p1: registered frame outputs, held between strobes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      frame_dv_o     <= 1'b0;
      frame_hdr_o    <= '0;
      frame_data_o   <= '0;
      frame_is_cmd_o <= 1'b0;
      hdr_err_o      <= 1'b0;
    end else begin
      frame_dv_o <= emit;
      if (emit) begin
        frame_hdr_o    <= cur.hdr;
        frame_data_o   <= cur.data;
        frame_is_cmd_o <= (cur.hdr == C_CMD_HEADER);
        hdr_err_o      <= cur_bad;
      end
    end
  end

endmodule
